// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Supports unsigned and two's-complement operands selected per operation,
// a start/busy/done handshake, and divide-by-zero / signed-overflow flags.
// Signed operands are reduced to magnitudes before the divide loop and the
// result signs are reapplied in a final fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;

  // Operands exactly as captured with ld (raw a is needed for the
  // divide-by-zero remainder, raw b for the overflow check).
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_sgn;

  // Divide loop: r_quo starts as |a| and fills with quotient bits from the
  // right, r_rem holds the partial remainder, r_div holds |b|.
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_div;
  logic [CW-1:0]     r_count;

  // Sign bookkeeping and exceptional-case markers from PREP.
  logic              r_qneg;
  logic              r_rneg;
  logic              r_zero_div;

  // Registered outputs.
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_r;
  logic              r_busy;
  logic              r_done;
  logic              r_dbz;
  logic              r_ovf;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic              w_accept;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic              w_b_zero;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_diff;
  logic              w_qbit;
  logic [WIDTH-1:0]  w_rem_next;
  logic [WIDTH-1:0]  w_q_fix;
  logic [WIDTH-1:0]  w_r_fix;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_min_val;

  assign w_min_val = {1'b1, {(WIDTH-1){1'b0}}};

  // A start request is taken only in IDLE, and not in the cycle that is
  // still presenting done: that cycle is the tail of the fix-up step.
  assign w_accept = (r_state == S_IDLE) && ld && !r_done;

  // Magnitudes: negate only for signed operands with the MSB set. The most
  // negative value negates to itself, which reads correctly as unsigned.
  assign w_mag_a  = (r_sgn && r_a[WIDTH-1]) ? (-r_a) : r_a;
  assign w_mag_b  = (r_sgn && r_b[WIDTH-1]) ? (-r_b) : r_b;
  assign w_b_zero = (r_b == '0);

  // Restoring step: shift {R, Q} left by one, trial-subtract |b| in
  // WIDTH+1 bits so the top bit of the difference is the borrow.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_qbit     = ~w_diff[WIDTH];
  // When the trial fails the shifted value is below |b| < 2^WIDTH, so its
  // top bit is zero and nothing is lost by keeping WIDTH bits.
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  // Final results: divide-by-zero bypasses the loop entirely; otherwise
  // the magnitudes get their signs back.
  assign w_q_fix = r_zero_div ? {WIDTH{1'b1}} : (r_qneg ? (-r_quo) : r_quo);
  assign w_r_fix = r_zero_div ? r_a           : (r_rneg ? (-r_rem) : r_rem);

  // MIN / -1 is the only signed quotient that cannot be represented; the
  // datapath already wraps it to MIN, this only raises the flag.
  assign w_ovf = r_sgn && !r_zero_div && (r_a == w_min_val) && (&r_b);

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  // Advance the control state; reset returns to IDLE and aborts any divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE -> PREP -> DIV (WIDTH steps) -> FIX -> IDLE,
  // with PREP jumping straight to FIX when the divisor is zero.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_PREP;
        end
      end
      S_PREP: begin
        if (w_b_zero) begin
          w_state_next = S_FIX;
        end else begin
          w_state_next = S_DIV;
        end
      end
      S_DIV: begin
        if (r_count == '0) begin
          w_state_next = S_FIX;
        end
      end
      S_FIX: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  // Capture operands, run the restoring loop, and publish results in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sgn      <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div      <= '0;
      r_count    <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_zero_div <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_sgn  <= sgn;
            r_busy <= 1'b1;
            // Flags describe the last operation; a new one clears them.
            // q/r are left alone so the previous result stays readable.
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        S_PREP: begin
          r_quo      <= w_mag_a;
          r_rem      <= '0;
          r_div      <= w_mag_b;
          r_qneg     <= r_sgn && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_rneg     <= r_sgn && r_a[WIDTH-1];
          r_zero_div <= w_b_zero;
          r_count    <= CW'(WIDTH - 1);
        end
        S_DIV: begin
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
          r_count <= r_count - CW'(1);
        end
        S_FIX: begin
          r_q    <= w_q_fix;
          r_r    <= w_r_fix;
          r_dbz  <= r_zero_div;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 16-bit and an 8-bit instance share one
// clock and reset; each task drives one scenario and checks its results.
module tb_seq_divider;

  logic        clk;
  logic        rst;

  logic        ld16, sgn16;
  logic [15:0] a16, b16, q16, r16;
  logic        busy16, done16, dbz16, ovf16;

  logic        ld8, sgn8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dbz8, ovf8;

  int total;
  int bad;

  seq_divider #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .ld(ld16), .sgn(sgn16), .a(a16), .b(b16),
    .q(q16), .r(r16), .busy(busy16), .done(done16), .dbz(dbz16), .ovf(ovf16)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .ld(ld8), .sgn(sgn8), .a(a8), .b(b8),
    .q(q8), .r(r8), .busy(busy8), .done(done8), .dbz(dbz8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one 16-bit operation in the cycle after the caller's current one,
  // then count edges after the accepting edge until done is seen.
  task automatic run16(input logic s, input logic [15:0] aa, input logic [15:0] bb,
                       output int lat, output logic busy_k, output logic [1:0] flags_k);
    @(posedge clk); #1;
    sgn16 = s; a16 = aa; b16 = bb; ld16 = 1'b1;
    @(posedge clk); #1;
    ld16 = 1'b0;
    busy_k = busy16;
    flags_k = {dbz16, ovf16};
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done16) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                      output int lat);
    @(posedge clk); #1;
    sgn8 = s; a8 = aa; b8 = bb; ld8 = 1'b1;
    @(posedge clk); #1;
    ld8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({q16, r16} !== 32'h0) begin
      bad++; $display("FAIL reset_qr got q=%h r=%h exp q=0000 r=0000", q16, r16);
    end
    total++;
    if ({busy16, done16, dbz16, ovf16} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl got busy/done/dbz/ovf=%b exp 0000",
                      {busy16, done16, dbz16, ovf16});
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b0, 16'd3473, 16'd147, lat, bk, fk);
    total++;
    if (lat !== 18) begin bad++; $display("FAIL t1_latency got=%0d exp=18", lat); end
    total++;
    if (bk !== 1'b1) begin bad++; $display("FAIL t1_busy got=%b exp=1", bk); end
    total++;
    if (q16 !== 16'd23 || r16 !== 16'd92) begin
      bad++; $display("FAIL t1_result got q=%0d r=%0d exp q=23 r=92", q16, r16);
    end
    total++;
    if (dbz16 !== 1'b0 || ovf16 !== 1'b0 || busy16 !== 1'b0) begin
      bad++; $display("FAIL t1_flags got dbz=%b ovf=%b busy=%b exp 0 0 0", dbz16, ovf16, busy16);
    end
    @(posedge clk); #1;
    total++;
    if (done16 !== 1'b0) begin bad++; $display("FAIL t1_done_pulse got=%b exp=0", done16); end
    $display("t1 3473/147 q=%0d r=%0d lat=%0d", q16, r16, lat);
  endtask

  task automatic test_signed();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b1, 16'hF26F, 16'd147, lat, bk, fk);
    total++;
    if (q16 !== 16'hFFE9 || r16 !== 16'hFFA4) begin
      bad++; $display("FAIL t2_neg_a got q=%h r=%h exp q=ffe9 r=ffa4", q16, r16);
    end
    $display("t2 -3473/147 q=%h r=%h", q16, r16);
    run16(1'b1, 16'd3473, 16'hFF6D, lat, bk, fk);
    total++;
    if (q16 !== 16'hFFE9 || r16 !== 16'h005C || lat !== 18) begin
      bad++; $display("FAIL t2_neg_b got q=%h r=%h lat=%0d exp q=ffe9 r=005c lat=18", q16, r16, lat);
    end
    $display("t2 3473/-147 q=%h r=%h", q16, r16);
  endtask

  // An ld pulse with different operands during a divide must be ignored.
  task automatic test_busy_ld();
    int done_at;
    logic [15:0] q_mid;
    @(posedge clk); #1;
    sgn16 = 1'b0; a16 = 16'd3473; b16 = 16'd147; ld16 = 1'b1;
    @(posedge clk); #1;
    ld16 = 1'b0;
    done_at = -1;
    q_mid = 16'h0;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin
        a16 = 16'd1; b16 = 16'd1; ld16 = 1'b1;
      end else begin
        ld16 = 1'b0;
      end
      if (n == 10) q_mid = q16;
      if (done16) done_at = n;
    end
    total++;
    if (q_mid !== 16'hFFE9) begin
      bad++; $display("FAIL t5_hold_q got=%h exp=ffe9", q_mid);
    end
    total++;
    if (done_at !== 18 || q16 !== 16'd23 || r16 !== 16'd92) begin
      bad++; $display("FAIL t5_ignore_ld got lat=%0d q=%0d r=%0d exp lat=18 q=23 r=92",
                      done_at, q16, r16);
    end
    @(posedge clk); #1;
    total++;
    if (busy16 !== 1'b0) begin bad++; $display("FAIL t5_no_restart got busy=%b exp=0", busy16); end
    $display("t5 busy-ld ignored q=%0d r=%0d lat=%0d", q16, r16, done_at);
  endtask

  task automatic test_div_zero();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b0, 16'd100, 16'd0, lat, bk, fk);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL t3_latency got=%0d exp=2", lat); end
    total++;
    if (q16 !== 16'hFFFF || r16 !== 16'd100 || dbz16 !== 1'b1 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL t3_dbz got q=%h r=%0d dbz=%b ovf=%b exp q=ffff r=100 dbz=1 ovf=0",
                      q16, r16, dbz16, ovf16);
    end
    $display("t3 100/0 q=%h r=%0d dbz=%b", q16, r16, dbz16);
    run16(1'b0, 16'd10, 16'd3, lat, bk, fk);
    total++;
    if (fk !== 2'b00) begin bad++; $display("FAIL t3_flag_clear got dbz/ovf=%b exp=00", fk); end
    total++;
    if (q16 !== 16'd3 || r16 !== 16'd1 || dbz16 !== 1'b0) begin
      bad++; $display("FAIL t3_after got q=%0d r=%0d dbz=%b exp q=3 r=1 dbz=0", q16, r16, dbz16);
    end
    $display("t3 10/3 q=%0d r=%0d", q16, r16);
    run16(1'b1, 16'hFFFB, 16'd0, lat, bk, fk);
    total++;
    if (q16 !== 16'hFFFF || r16 !== 16'hFFFB || dbz16 !== 1'b1 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL t3_signed_dbz got q=%h r=%h dbz=%b ovf=%b exp q=ffff r=fffb dbz=1 ovf=0",
                      q16, r16, dbz16, ovf16);
    end
    $display("t3 -5/0 q=%h r=%h", q16, r16);
  endtask

  task automatic test_overflow();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b1, 16'h8000, 16'hFFFF, lat, bk, fk);
    total++;
    if (q16 !== 16'h8000 || r16 !== 16'h0000 || ovf16 !== 1'b1 || dbz16 !== 1'b0) begin
      bad++; $display("FAIL t4_ovf got q=%h r=%h ovf=%b dbz=%b exp q=8000 r=0000 ovf=1 dbz=0",
                      q16, r16, ovf16, dbz16);
    end
    $display("t4 signed MIN/-1 q=%h r=%h ovf=%b", q16, r16, ovf16);
    run16(1'b0, 16'h8000, 16'hFFFF, lat, bk, fk);
    total++;
    if (fk !== 2'b00) begin bad++; $display("FAIL t4_flag_clear got dbz/ovf=%b exp=00", fk); end
    total++;
    if (q16 !== 16'h0000 || r16 !== 16'h8000 || ovf16 !== 1'b0) begin
      bad++; $display("FAIL t4_unsigned got q=%h r=%h ovf=%b exp q=0000 r=8000 ovf=0", q16, r16, ovf16);
    end
    $display("t4 unsigned 8000/ffff q=%h r=%h", q16, r16);
  endtask

  task automatic test_zero_dividend();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b1, 16'd0, 16'd5, lat, bk, fk);
    total++;
    if (lat !== 18 || q16 !== 16'd0 || r16 !== 16'd0) begin
      bad++; $display("FAIL zero_dividend got lat=%0d q=%0d r=%0d exp lat=18 q=0 r=0", lat, q16, r16);
    end
    $display("zero 0/5 q=%0d r=%0d lat=%0d", q16, r16, lat);
  endtask

  // ld in the done cycle is dropped; ld one cycle later starts normally.
  task automatic test_back_to_back();
    int lat; logic bk; logic [1:0] fk;
    run16(1'b0, 16'd50, 16'd7, lat, bk, fk);
    sgn16 = 1'b0; a16 = 16'd9; b16 = 16'd2; ld16 = 1'b1;
    @(posedge clk); #1;
    ld16 = 1'b0;
    total++;
    if (busy16 !== 1'b0 || q16 !== 16'd7 || r16 !== 16'd1) begin
      bad++; $display("FAIL b2b_done_cycle_ld got busy=%b q=%0d r=%0d exp busy=0 q=7 r=1",
                      busy16, q16, r16);
    end
    run16(1'b0, 16'd9, 16'd2, lat, bk, fk);
    total++;
    if (bk !== 1'b1 || lat !== 18 || q16 !== 16'd4 || r16 !== 16'd1) begin
      bad++; $display("FAIL b2b_next got busy=%b lat=%0d q=%0d r=%0d exp busy=1 lat=18 q=4 r=1",
                      bk, lat, q16, r16);
    end
    $display("b2b 50/7 then 9/2 q=%0d r=%0d", q16, r16);
  endtask

  task automatic test_abort();
    int lat; logic bk; logic [1:0] fk; int done_seen;
    @(posedge clk); #1;
    sgn16 = 1'b0; a16 = 16'd3473; b16 = 16'd147; ld16 = 1'b1;
    @(posedge clk); #1;
    ld16 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({q16, r16} !== 32'h0 || {busy16, done16, dbz16, ovf16} !== 4'b0000) begin
      bad++; $display("FAIL t5_abort_clear got q=%h r=%h busy/done/dbz/ovf=%b exp all zero",
                      q16, r16, {busy16, done16, dbz16, ovf16});
    end
    done_seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done16 || busy16) done_seen++;
    end
    total++;
    if (done_seen !== 0) begin bad++; $display("FAIL t5_abort_quiet got=%0d exp=0", done_seen); end
    run16(1'b0, 16'd1000, 16'd7, lat, bk, fk);
    total++;
    if (lat !== 18 || q16 !== 16'd142 || r16 !== 16'd6) begin
      bad++; $display("FAIL t5_after_abort got lat=%0d q=%0d r=%0d exp lat=18 q=142 r=6", lat, q16, r16);
    end
    $display("t5 abort then 1000/7 q=%0d r=%0d", q16, r16);
  endtask

  task automatic test_width8();
    int lat;
    run8(1'b0, 8'd200, 8'd7, lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL t6_latency got=%0d exp=10", lat); end
    total++;
    if (q8 !== 8'd28 || r8 !== 8'd4) begin
      bad++; $display("FAIL t6_unsigned got q=%0d r=%0d exp q=28 r=4", q8, r8);
    end
    $display("t6 200/7 q=%0d r=%0d lat=%0d", q8, r8, lat);
    run8(1'b1, 8'h80, 8'd3, lat);
    total++;
    if (q8 !== 8'hD6 || r8 !== 8'hFE || ovf8 !== 1'b0) begin
      bad++; $display("FAIL t6_signed got q=%h r=%h ovf=%b exp q=d6 r=fe ovf=0", q8, r8, ovf8);
    end
    $display("t6 -128/3 q=%h r=%h", q8, r8);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    ld16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    ld8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_busy_ld();
    test_div_zero();
    test_overflow();
    test_zero_dividend();
    test_back_to_back();
    test_abort();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
